// File: rtl/sh7604_sci_ctrl.sv
// SH7604 SCI bus-master sequencer: runs the SCI init sequence, then streams TX FIFO bytes to TDR.
// Optional macro SCI_CTRL_IRQ_WAIT_EN: leave WAIT on TXI_IRQ, with POLL_DLY as timeout.
module sh7604_sci_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_DLY   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic        CFG_START,
  input  logic [7:0]  CFG_SMR,
  input  logic [7:0]  CFG_BRR,
  input  logic [7:0]  CFG_SCR,
  input  logic        ABORT,
  input  logic        PUSH,
  input  logic [7:0]  PUSH_DATA,
  output logic        FULL,
  output logic        EMPTY,
  output logic        READY,
  output logic [15:0] TX_CNT,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        TXI_IRQ
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] POLL_LAST = 16'(POLL_DLY - 1);
  localparam logic [2:0] OFF_SMR = 3'd0, OFF_BRR = 3'd1, OFF_SCR = 3'd2,
                         OFF_TDR = 3'd3, OFF_SSR = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_RUN, S_RD_SSR, S_WAIT, S_WR_TDR, S_CLR
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  ba;
    logic        we;
  } bus_t;

  function automatic bus_t mk(input logic [2:0] off, input logic [7:0] d, input logic we);
    bus_t b;
    b.a  = 32'hFFFF_FE00 | {29'd0, off};
    b.d  = {4{d}};
    b.we = we;
    case (off)
      3'd1:    b.ba = 4'b0100;
      3'd2:    b.ba = 4'b0010;
      3'd3:    b.ba = 4'b0001;
      default: b.ba = 4'b1000;
    endcase
    return b;
  endfunction

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      smr_q, brr_q, scr_q;
  logic [15:0]     wait_cnt;
  logic            abort_pend;
  logic            ce, bus_done, abort_go, start_ok, push_ok, pop, tdre, wait_done;
  logic            unused_ok;

  assign ce       = CE_R & EN;
  assign bus_done = IBUS_REQ & ~IBUS_BUSY;
  // A pending abort may only take effect once no bus cycle is left stalled.
  assign abort_go = (ABORT | abort_pend) & ~(IBUS_REQ & IBUS_BUSY);
  assign start_ok = CFG_START & ~ABORT & ((state == S_IDLE) | (state == S_RUN));
  assign push_ok  = PUSH & (count != DEPTH_C) & ~abort_go;
  assign pop      = bus_done & (state == S_WR_TDR);
  assign tdre     = IBUS_DI[31];
  assign FULL     = (count == DEPTH_C);
  assign EMPTY    = (count == '0);
  assign READY    = (state == S_RUN);

`ifdef SCI_CTRL_IRQ_WAIT_EN
  assign wait_done = TXI_IRQ | (wait_cnt == POLL_LAST);
  assign unused_ok = ^{CE_F, IBUS_DI[30:0]};
`else
  assign wait_done = (wait_cnt == POLL_LAST);
  assign unused_ok = ^{CE_F, IBUS_DI[30:0], TXI_IRQ};
`endif

  always_ff @(posedge CLK) begin
    if (ce && push_ok) mem[wr_ptr] <= PUSH_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      smr_q      <= '0;
      brr_q      <= '0;
      scr_q      <= '0;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
      TX_CNT     <= '0;
      IBUS_A     <= '0;
      IBUS_DO    <= '0;
      IBUS_BA    <= '0;
      IBUS_WE    <= 1'b0;
      IBUS_REQ   <= 1'b0;
    end else if (ce) begin
      if (abort_go) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      end

      if (pop)           TX_CNT <= TX_CNT + 16'd1;
      else if (start_ok) TX_CNT <= '0;

      // Default: drop REQ after completion; a back-to-back issue below overrides it.
      if (bus_done) IBUS_REQ <= 1'b0;
      if (ABORT && IBUS_REQ && IBUS_BUSY) abort_pend <= 1'b1;

      if (abort_go) begin
        state      <= S_IDLE;
        abort_pend <= 1'b0;
      end else if (start_ok) begin
        smr_q <= CFG_SMR;
        brr_q <= CFG_BRR;
        scr_q <= CFG_SCR;
        {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SCR, 8'h00, 1'b1);
        IBUS_REQ <= 1'b1;
        state    <= S_CFG0;
      end else begin
        case (state)
          S_CFG0: if (bus_done) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SMR, smr_q, 1'b1);
            IBUS_REQ <= 1'b1;
            state    <= S_CFG1;
          end
          S_CFG1: if (bus_done) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_BRR, brr_q, 1'b1);
            IBUS_REQ <= 1'b1;
            state    <= S_CFG2;
          end
          S_CFG2: if (bus_done) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SCR, scr_q, 1'b1);
            IBUS_REQ <= 1'b1;
            state    <= S_CFG3;
          end
          S_CFG3: if (bus_done) state <= S_RUN;
          S_RUN: if (!EMPTY) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SSR, 8'h00, 1'b0);
            IBUS_REQ <= 1'b1;
            state    <= S_RD_SSR;
          end
          S_RD_SSR: if (bus_done) begin
            if (tdre) begin
              {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_TDR, mem[rd_ptr], 1'b1);
              IBUS_REQ <= 1'b1;
              state    <= S_WR_TDR;
            end else begin
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end
          S_WAIT: if (wait_done) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SSR, 8'h00, 1'b0);
            IBUS_REQ <= 1'b1;
            state    <= S_RD_SSR;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
          S_WR_TDR: if (bus_done) begin
            {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} <= mk(OFF_SSR, 8'h78, 1'b1);
            IBUS_REQ <= 1'b1;
            state    <= S_CLR;
          end
          S_CLR: if (bus_done) state <= S_RUN;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sh7604_sci_ctrl.sv
// Randomized bench for sh7604_sci_ctrl: an IBUS slave logs completed cycles, compared to a transaction-level model.
module tb_sh7604_sci_ctrl;
  localparam int DEPTH = 8;
  localparam int POLL  = 16;

  logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b0, CE_F = 1'b0, EN = 1'b1;
  logic        CFG_START = 1'b0, ABORT = 1'b0, PUSH = 1'b0, TXI_IRQ = 1'b0, IBUS_BUSY = 1'b0;
  logic [7:0]  CFG_SMR = '0, CFG_BRR = '0, CFG_SCR = '0, PUSH_DATA = '0;
  logic [31:0] IBUS_DI = '0;
  logic        FULL, EMPTY, READY, IBUS_WE, IBUS_REQ;
  logic [15:0] TX_CNT;
  logic [31:0] IBUS_A, IBUS_DO;
  logic [3:0]  IBUS_BA;

  sh7604_sci_ctrl #(.FIFO_DEPTH(DEPTH), .POLL_DLY(POLL)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
    .CFG_START(CFG_START), .CFG_SMR(CFG_SMR), .CFG_BRR(CFG_BRR), .CFG_SCR(CFG_SCR),
    .ABORT(ABORT), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA), .FULL(FULL), .EMPTY(EMPTY),
    .READY(READY), .TX_CNT(TX_CNT), .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI),
    .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY),
    .TXI_IRQ(TXI_IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] ba; logic we; int t; } txn_t;
  typedef struct { int off; logic [7:0] b; logic we; } exp_t;

  txn_t       log_q[$];
  exp_t       exp_q[$];
  logic [7:0] ssr_q[$];
  int  n_chk = 0, n_bad = 0, tick_n = 0, exp_tx = 0;
  bit  rand_busy = 0, stall_clr = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CE_R tick (with random idle clocks before it); the slave side logs completed cycles.
  task automatic tick();
    int gap;
    logic done, req_b;
    logic [7:0] rsp;
    logic [68:0] snap;
    txn_t tr;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge CLK); #1; end
    IBUS_BUSY = (rand_busy && $urandom_range(0, 3) == 0) ||
                (stall_clr && IBUS_REQ && IBUS_WE && IBUS_A == 32'hFFFF_FE04);
    if (ssr_q.size() > 0) rsp = ssr_q[0];
    else                  rsp = 8'h80 | 8'($urandom_range(0, 127));
    IBUS_DI = {rsp, 24'($urandom)};
    req_b = IBUS_REQ;
    done  = EN && IBUS_REQ && !IBUS_BUSY;
    snap  = {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE};
    CE_R = 1'b1;
    @(posedge CLK); #1;
    CE_R = 1'b0;
    tick_n++;
    if (done) begin
      tr.a = snap[68:37]; tr.d = snap[36:5]; tr.ba = snap[4:1]; tr.we = snap[0]; tr.t = tick_n;
      log_q.push_back(tr);
      if (!tr.we && ssr_q.size() > 0) void'(ssr_q.pop_front());
    end else if (req_b) begin
      chk("bus_hold", {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE}, snap);
      chk("req_hold", IBUS_REQ, 1);
    end
  endtask

  task automatic exp_push(input int off, input logic [7:0] b, input logic we);
    exp_t e;
    e.off = off; e.b = b; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      int sh;
      logic [3:0] eba;
      sh  = 8 * (3 - (exp_q[i].off % 4));
      eba = 4'b1000 >> (exp_q[i].off % 4);
      chk({tag, "_addr"}, log_q[i].a, 32'hFFFF_FE00 + exp_q[i].off);
      chk({tag, "_we"}, log_q[i].we, exp_q[i].we);
      chk({tag, "_ba"}, log_q[i].ba, eba);
      if (exp_q[i].we) chk({tag, "_data"}, (log_q[i].d >> sh) & 32'hFF, exp_q[i].b);
      if (i > 0 && !exp_q[i].we && !exp_q[i-1].we)
        chk({tag, "_poll_gap"}, (log_q[i].t - log_q[i-1].t) >= POLL, 1);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic run_all(input string tag);
    for (int i = 0; i < 5000 && log_q.size() < exp_q.size(); i++) tick();
    repeat (3) tick();
    compare_log(tag);
  endtask

  task automatic push_byte(input logic [7:0] b);
    PUSH = 1'b1; PUSH_DATA = b;
    tick();
    PUSH = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] smr, input logic [7:0] brr, input logic [7:0] scr);
    CFG_SMR = smr; CFG_BRR = brr; CFG_SCR = scr;
    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
    exp_push(2, 8'h00, 1); exp_push(0, smr, 1); exp_push(1, brr, 1); exp_push(2, scr, 1);
  endtask

  // n bytes, each SSR-polled a random number of times before TDRE reads as 1.
  task automatic stream(input int n, input bit freeze);
    logic [7:0] bq[$];
    logic [88:0] snap;
    for (int i = 0; i < n; i++) begin
      logic [7:0] bb;
      int nz;
      bb = 8'($urandom);
      nz = $urandom_range(0, 3);
      bq.push_back(bb);
      repeat (nz) begin
        ssr_q.push_back(8'($urandom_range(0, 127)));
        exp_push(4, 8'h00, 0);
      end
      ssr_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
      exp_push(4, 8'h00, 0); exp_push(3, bb, 1); exp_push(4, 8'h78, 1);
    end
    foreach (bq[i]) push_byte(bq[i]);
    if (freeze) begin
      EN = 1'b0;
      snap = {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, TX_CNT, FULL, EMPTY, READY};
      PUSH = 1'b1; PUSH_DATA = 8'hA5;
      repeat (5) tick();
      PUSH = 1'b0;
      chk("en_freeze", {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, TX_CNT, FULL, EMPTY, READY}, snap);
      EN = 1'b1;
    end
    run_all("stream");
    exp_tx += n;
    chk("stream_tx_cnt", TX_CNT, exp_tx);
    chk("stream_empty", EMPTY, 1);
    chk("stream_ready", READY, 1);
  endtask

  initial begin
    logic [7:0] fill [9];
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_full", FULL, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_ready", READY, 0);
    chk("rst_tx_cnt", TX_CNT, 0);
    chk("rst_bus", {IBUS_REQ, IBUS_WE, IBUS_A, IBUS_DO, IBUS_BA}, 0);
    RST_N = 1'b1;
    repeat (3) tick();

    // Fill while IDLE: 9th push is dropped, nothing goes on the bus.
    for (int i = 0; i < 9; i++) begin
      fill[i] = 8'($urandom);
      push_byte(fill[i]);
      if (i == 6) chk("full_at_7", FULL, 0);
      if (i == 7) chk("full_at_8", FULL, 1);
    end
    chk("full_after_9", FULL, 1);
    chk("idle_quiet", log_q.size(), 0);
    do_cfg(8'h00, 8'h05, 8'h30);
    for (int i = 0; i < 8; i++) begin
      exp_push(4, 8'h00, 0); exp_push(3, fill[i], 1); exp_push(4, 8'h78, 1);
    end
    run_all("fill");
    exp_tx = 8;
    chk("fill_tx_cnt", TX_CNT, exp_tx);
    chk("fill_empty", EMPTY, 1);
    chk("fill_ready", READY, 1);

    rand_busy = 1;
    stream(5, 0);
    stream(3, 1);

    // ABORT during a stalled CLR write: cycle finishes, rest of FIFO is flushed.
    rand_busy = 0;
    stall_clr = 1;
    begin
      logic [7:0] b0;
      b0 = 8'($urandom);
      push_byte(b0); push_byte(8'($urandom)); push_byte(8'($urandom));
      for (int i = 0; i < 200 && !(IBUS_REQ && IBUS_WE && IBUS_A == 32'hFFFF_FE04); i++) tick();
      chk("clr_seen", IBUS_REQ && IBUS_WE && IBUS_A == 32'hFFFF_FE04, 1);
      tick();
      ABORT = 1'b1; tick(); ABORT = 1'b0;
      tick();
      chk("abort_req_kept", IBUS_REQ, 1);
      stall_clr = 0;
      repeat (3) tick();
      chk("abort_req", IBUS_REQ, 0);
      chk("abort_ready", READY, 0);
      chk("abort_empty", EMPTY, 1);
      exp_push(4, 8'h00, 0); exp_push(3, b0, 1); exp_push(4, 8'h78, 1);
      repeat (5) tick();
      compare_log("abort");
      exp_tx += 1;
      chk("abort_tx_cnt", TX_CNT, exp_tx);
    end

    // IDLE accepts pushes; ABORT beats a simultaneous CFG_START.
    push_byte(8'($urandom));
    repeat (8) tick();
    chk("idle_push_empty", EMPTY, 0);
    chk("idle_push_quiet", log_q.size(), 0);
    CFG_START = 1'b1; ABORT = 1'b1;
    tick();
    CFG_START = 1'b0; ABORT = 1'b0;
    repeat (8) tick();
    chk("abort_wins_ready", READY, 0);
    chk("abort_wins_empty", EMPTY, 1);
    chk("abort_wins_quiet", log_q.size(), 0);

    do_cfg(8'($urandom), 8'($urandom), 8'($urandom));
    run_all("cfg2");
    exp_tx = 0;
    chk("cfg2_tx_clr", TX_CNT, 0);
    chk("cfg2_ready", READY, 1);
    rand_busy = 1;
    stream(4, 0);

    // Asynchronous reset in the middle of a stalled cycle.
    rand_busy = 0;
    stall_clr = 1;
    push_byte(8'($urandom));
    for (int i = 0; i < 200 && !(IBUS_REQ && IBUS_WE && IBUS_A == 32'hFFFF_FE04); i++) tick();
    chk("rst_clr_seen", IBUS_REQ, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", IBUS_REQ, 0);
    chk("rst_mid_tx_cnt", TX_CNT, 0);
    chk("rst_mid_ready", READY, 0);
    chk("rst_mid_empty", EMPTY, 1);

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end
endmodule
